// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 keypad matrix scanner with debounce and key event FIFO

module keypad_event_fifo #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_tdata,
    input  logic         in_tvalid,
    output logic [W-1:0] out_tdata,
    output logic         out_tvalid,
    input  logic         out_tready,
    output logic         overflow
);

    logic [W-1:0] mem [4];
    logic [1:0]   wr_ptr;
    logic [1:0]   rd_ptr;
    logic [2:0]   count;
    logic         full;
    logic         pop;
    logic         push_ok;

    assign full       = (count == 3'd4);
    assign out_tvalid = (count != 3'd0);
    assign out_tdata  = mem[rd_ptr];
    assign pop        = out_tvalid && out_tready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push_ok    = in_tvalid && (!full || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            count    <= 3'd0;
            overflow <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= in_tdata;
                wr_ptr      <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
            if (in_tvalid && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

module keypad_scan #(
    parameter int rate     = 1000,
    parameter int clk_f    = 100000000,
    parameter int clk_d    = clk_f / (rate * 4),
    parameter int DEBOUNCE = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic [15:0] keys,
    output logic        key_valid,
    output logic [4:0]  key_code,
    input  logic        key_ready,
    output logic        overflow
);

    localparam int             CW         = $clog2(clk_d);
    localparam logic [CW-1:0]  C_LAST     = CW'(clk_d - 1);
    localparam logic [3:0]     STABLE_MAX = 4'(DEBOUNCE - 1);

    logic [CW-1:0] c;
    logic [1:0]    idx;
    logic [15:0]   scan;
    logic [15:0]   prev;
    logic [15:0]   pending;
    logic [3:0]    stable_cnt;

    logic          slot_end;
    logic          scan_done;
    logic [15:0]   scan_next;
    logic [3:0]    stable_next;
    logic          update_keys;
    logic          ev_valid;
    logic [3:0]    ev_idx;
    logic [15:0]   ev_mask;
    logic [4:0]    ev_code;

    // Rows are sampled at the end of each column slot so the lines have settled.
    always_comb begin
        slot_end  = (c == C_LAST);
        scan_done = slot_end && (idx == 2'd3);
        scan_next = scan;
        if (slot_end) begin
            scan_next[{idx, 2'b00} +: 4] = ~row;
        end
        if (scan_next == prev) begin
            stable_next = (stable_cnt == STABLE_MAX) ? stable_cnt : stable_cnt + 4'd1;
        end else begin
            stable_next = 4'd0;
        end
        update_keys = scan_done && (stable_next == STABLE_MAX) && (scan_next != keys);
    end

    // Lowest pending key goes first; descending loop leaves the lowest index.
    always_comb begin
        ev_valid = |pending;
        ev_idx   = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (pending[i]) begin
                ev_idx = 4'(i);
            end
        end
        ev_mask = ev_valid ? (16'd1 << ev_idx) : 16'd0;
        ev_code = {keys[ev_idx], ev_idx};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c          <= '0;
            idx        <= 2'd0;
            col        <= 4'b1110;
            scan       <= 16'd0;
            prev       <= 16'd0;
            keys       <= 16'd0;
            stable_cnt <= 4'd0;
            pending    <= 16'd0;
        end else begin
            c   <= slot_end ? '0 : c + 1'b1;
            col <= ~(4'b0001 << idx);
            if (slot_end) begin
                idx <= idx + 2'd1;
            end
            scan <= scan_next;
            if (scan_done) begin
                stable_cnt <= stable_next;
                if (scan_next != prev) begin
                    prev <= scan_next;
                end
            end
            if (update_keys) begin
                keys <= scan_next;
            end
            pending <= (pending & ~ev_mask) | (update_keys ? (scan_next ^ keys) : 16'd0);
        end
    end

    keypad_event_fifo #(
        .W (5)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .in_tdata   (ev_code),
        .in_tvalid  (ev_valid),
        .out_tdata  (key_code),
        .out_tvalid (key_valid),
        .out_tready (key_ready),
        .overflow   (overflow)
    );

endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - directed self-checking bench for keypad_scan

module tb_keypad_scan;

    logic        clk;
    logic        rst;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [15:0] keys;
    logic        key_valid;
    logic [4:0]  key_code;
    logic        key_ready;
    logic        overflow;

    logic [15:0] pressed;
    int          cyc;
    int          vectors;
    int          miscompares;

    keypad_scan #(
        .rate     (10),
        .clk_f    (4000),
        .DEBOUNCE (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row       (row),
        .col       (col),
        .keys      (keys),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_ready (key_ready),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad model: a held key pulls its row low while its column is driven low.
    always_comb begin
        row = 4'hF;
        for (int cc = 0; cc < 4; cc++) begin
            if (!col[cc]) begin
                for (int rr = 0; rr < 4; rr++) begin
                    if (pressed[cc*4 + rr]) row[rr] = 1'b0;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic goto(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        key_ready   = 1'b0;
        pressed     = 16'h0000;
        repeat (3) @(negedge clk);

        check("rst_col", 32'(col), 32'h0000000E);
        check("rst_keys", 32'(keys), 32'h0);
        check("rst_valid", 32'(key_valid), 32'h0);
        check("rst_ovf", 32'(overflow), 32'h0);
        rst = 1'b0;

        goto(100);  check("idle_col0_hold", 32'(col), 32'hE);
        goto(101);  check("idle_col1", 32'(col), 32'hD);
        goto(201);  check("idle_col2", 32'(col), 32'hB);
        goto(301);  check("idle_col3", 32'(col), 32'h7);
        goto(401);  check("idle_col0", 32'(col), 32'hE);
        check("idle_keys", 32'(keys), 32'h0);
        check("idle_valid", 32'(key_valid), 32'h0);

        pressed = 16'h0040;
        goto(1599); check("k6_not_yet", 32'(keys), 32'h0);
        goto(1600); check("k6_keys", 32'(keys), 32'h0040);
        goto(1601); check("k6_valid", 32'(key_valid), 32'h1);
        check("k6_press_code", 32'(key_code), 32'h16);
        key_ready = 1'b1;
        goto(1602); check("k6_popped", 32'(key_valid), 32'h0);
        key_ready = 1'b0;

        pressed = 16'h0000;
        goto(2799); check("k6_rel_not_yet", 32'(keys), 32'h0040);
        goto(2800); check("k6_rel_keys", 32'(keys), 32'h0);
        goto(2801); check("k6_rel_valid", 32'(key_valid), 32'h1);
        check("k6_rel_code", 32'(key_code), 32'h06);
        key_ready = 1'b1;
        goto(2802); check("k6_rel_popped", 32'(key_valid), 32'h0);
        key_ready = 1'b0;

        pressed = 16'h0001;
        goto(3201); pressed = 16'h0000;
        goto(3601); pressed = 16'h0001;
        goto(4001); pressed = 16'h0000;
        check("bounce_no_event_a", 32'(key_valid), 32'h0);
        goto(4401); pressed = 16'h0001;
        check("bounce_no_event_b", 32'(key_valid), 32'h0);
        goto(5599); check("bounce_keys_hold", 32'(keys), 32'h0);
        check("bounce_no_event_c", 32'(key_valid), 32'h0);
        goto(5600); check("k0_keys", 32'(keys), 32'h0001);
        goto(5601); check("k0_valid", 32'(key_valid), 32'h1);
        check("k0_code", 32'(key_code), 32'h10);
        key_ready = 1'b1;
        goto(5602); check("k0_popped", 32'(key_valid), 32'h0);
        key_ready = 1'b0;

        pressed = 16'h8217;
        goto(5700); check("k0_single_event", 32'(key_valid), 32'h0);
        goto(6800); check("multi_keys", 32'(keys), 32'h8217);
        goto(6804); check("multi_ovf_before", 32'(overflow), 32'h0);
        goto(6805); check("multi_ovf_set", 32'(overflow), 32'h1);
        check("multi_head0", 32'(key_code), 32'h11);
        key_ready = 1'b1;
        goto(6806); check("multi_head1", 32'(key_code), 32'h12);
        goto(6807); check("multi_head2", 32'(key_code), 32'h14);
        goto(6808); check("multi_head3", 32'(key_code), 32'h19);
        goto(6809); check("multi_empty", 32'(key_valid), 32'h0);
        check("multi_ovf_sticky", 32'(overflow), 32'h1);
        key_ready = 1'b0;

        rst = 1'b1;
        @(negedge clk);
        check("rst2_ovf", 32'(overflow), 32'h0);
        check("rst2_keys", 32'(keys), 32'h0);
        rst = 1'b0;

        goto(1200); check("full_keys", 32'(keys), 32'h8217);
        goto(1204); check("full_head", 32'(key_code), 32'h10);
        check("full_ovf_pre", 32'(overflow), 32'h0);
        key_ready = 1'b1;
        goto(1205); check("full_pushpop_head", 32'(key_code), 32'h11);
        check("full_pushpop_ovf", 32'(overflow), 32'h0);
        goto(1206); check("full_pushpop2_head", 32'(key_code), 32'h12);
        check("full_pushpop2_ovf", 32'(overflow), 32'h0);

        rst = 1'b1;
        @(negedge clk);
        check("middrain_valid", 32'(key_valid), 32'h0);
        check("middrain_ovf", 32'(overflow), 32'h0);
        check("middrain_col", 32'(col), 32'hE);
        rst = 1'b0;
        goto(50);  check("post_rst_quiet", 32'(key_valid), 32'h0);
        goto(101); check("post_rst_col1", 32'(col), 32'hD);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
